// File: rtl/hs_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hs_arbiter
// Description : Round-robin arbiter sharing one 4-phase handshake resource
//               between N requesters, with C-element style completion.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_arbiter #(
    parameter int N  = 4,
    parameter int GW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  ack,
    output logic          res_req,
    input  logic          res_ack,
    output logic [GW-1:0] grant_id,
    output logic          busy,
    output logic          proto_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_HOLD = 2'd2,
        S_RTZ  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_ack;
    logic [N-1:0]   w_ack_nxt;
    logic           r_res_req;
    logic           w_res_req_nxt;
    logic [GW-1:0]  r_grant;
    logic [GW-1:0]  w_grant_nxt;
    logic [GW-1:0]  r_last;
    logic [GW-1:0]  w_last_nxt;
    logic           r_err;
    logic           w_err_nxt;
    logic           r_busy;
    logic           r_res_ack_q;

    logic           w_found;
    logic [GW-1:0]  w_win;
    logic [GW-1:0]  w_idx;
    logic [N-1:0]   w_grant_onehot;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 1; i <= N; i++) begin
            w_idx = GW'((int'(r_last) + i) % N);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_grant_onehot = {{(N-1){1'b0}}, 1'b1} << r_grant;

    always_comb begin
        w_state_nxt   = r_state;
        w_ack_nxt     = r_ack;
        w_res_req_nxt = r_res_req;
        w_grant_nxt   = r_grant;
        w_last_nxt    = r_last;
        w_err_nxt     = r_err;
        case (r_state)
            S_IDLE: begin
                // A resource still holding res_ack high has not returned to zero.
                if (w_found && !res_ack) begin
                    w_grant_nxt   = w_win;
                    w_last_nxt    = w_win;
                    w_res_req_nxt = 1'b1;
                    w_state_nxt   = S_FWD;
                end
            end
            S_FWD: begin
                if (!req[r_grant]) begin
                    w_err_nxt = 1'b1;
                end
                if (res_ack) begin
                    w_ack_nxt   = w_grant_onehot;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!res_ack) begin
                    w_err_nxt = 1'b1;
                end
                if (!req[r_grant]) begin
                    w_res_req_nxt = 1'b0;
                    w_state_nxt   = S_RTZ;
                end
            end
            S_RTZ: begin
                if (res_ack && !r_res_ack_q) begin
                    w_err_nxt = 1'b1;
                end
                if (!res_ack) begin
                    w_ack_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_ack_nxt     = '0;
                w_res_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ack       <= '0;
            r_res_req   <= 1'b0;
            r_grant     <= '0;
            r_last      <= GW'(N - 1);
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_res_ack_q <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ack       <= w_ack_nxt;
            r_res_req   <= w_res_req_nxt;
            r_grant     <= w_grant_nxt;
            r_last      <= w_last_nxt;
            r_err       <= w_err_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_res_ack_q <= res_ack;
        end
    end

    assign ack       = r_ack;
    assign res_req   = r_res_req;
    assign grant_id  = r_grant;
    assign busy      = r_busy;
    assign proto_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hs_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_hs_arbiter
// Description : Self-checking bench for hs_arbiter with a grant scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_arbiter;

    localparam int N       = 4;
    localparam int GW      = 2;
    localparam int RES_DLY = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  ack;
    logic          res_req;
    logic          res_ack;
    logic [GW-1:0] grant_id;
    logic          busy;
    logic          proto_err;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            exp_q[$];
    bit            res_auto;
    bit            req_auto;
    int            res_cnt;
    logic          res_seen;
    logic [N-1:0]  prev_ack;
    int            want[N];

    hs_arbiter #(.N(N)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ack       (ack),
        .res_req   (res_req),
        .res_ack   (res_ack),
        .grant_id  (grant_id),
        .busy      (busy),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: sample after the edge, score grants, then advance the resource/requester models.
    task automatic cycle();
        @(posedge clk);
        #1;
        check("ack_onehot0", 32'($countones(ack) <= 1), 1);
        if ((ack & ~prev_ack) != '0) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_grant", 32'(ack), 0);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("sb_ack", 32'(ack), 32'(1) << e);
                check("sb_grant_id", 32'(grant_id), e);
            end
        end
        prev_ack = ack;
        if (res_auto) begin
            if (res_req != res_seen) begin
                res_seen = res_req;
                res_cnt  = RES_DLY;
            end
            if (res_cnt > 0) begin
                res_cnt--;
                if (res_cnt == 0) res_ack = res_seen;
            end
        end
        if (req_auto) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && ack[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && !ack[i] && want[i] > 0) begin
                    req[i] = 1'b1;
                    want[i]--;
                end
            end
        end
    endtask

    task automatic run_done(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || req != '0) && n < budget) begin
            cycle();
            n++;
        end
        check("run_done_timeout", 32'(n < budget), 1);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req      = '0;
        res_ack  = 1'b0;
        res_seen = 1'b0;
        res_cnt  = 0;
        @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 0);
        check("rst_res_req", 32'(res_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_proto_err", 32'(proto_err), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        prev_ack = '0;
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        req      = '0;
        res_ack  = 1'b0;
        res_auto = 1'b1;
        req_auto = 1'b1;
        res_seen = 1'b0;
        res_cnt  = 0;
        prev_ack = '0;
        for (int i = 0; i < N; i++) want[i] = 0;

        // Single requester with exact phase latencies
        do_reset();
        exp_q.push_back(0);
        req = 4'b0001;
        cycle();
        check("single_res_req_rise", 32'(res_req), 1);
        check("single_busy", 32'(busy), 1);
        check("single_ack_early", 32'(ack), 0);
        cycle();
        check("single_ack_wait", 32'(ack), 0);
        cycle();
        check("single_ack_rise", 32'(ack), 4'b0001);
        cycle();
        check("single_res_req_fall", 32'(res_req), 0);
        check("single_ack_hold", 32'(ack), 4'b0001);
        cycle();
        check("single_ack_rtz_wait", 32'(ack), 4'b0001);
        cycle();
        check("single_ack_fall", 32'(ack), 0);
        check("single_busy_fall", 32'(busy), 0);
        check("single_grant_id", 32'(grant_id), 0);

        // Round-robin with all requesters; requester 0 asks twice
        do_reset();
        want[0] = 1;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        req = 4'b1111;
        run_done(400);

        // Wrap and skip after a grant to requester 2
        do_reset();
        exp_q.push_back(2);
        req = 4'b0100;
        run_done(100);
        exp_q.push_back(3);
        exp_q.push_back(0);
        req = 4'b1001;
        run_done(200);
        check("wrap_grant_id_holds", 32'(grant_id), 0);

        // Resource still high in IDLE blocks arbitration
        res_auto = 1'b0;
        res_ack  = 1'b1;
        exp_q.push_back(1);
        req = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("blocked_res_req", 32'(res_req), 0);
            check("blocked_busy", 32'(busy), 0);
        end
        res_ack = 1'b0;
        cycle();
        check("unblocked_res_req", 32'(res_req), 1);
        check("unblocked_grant_id", 32'(grant_id), 1);
        res_seen = 1'b0;
        res_auto = 1'b1;
        run_done(100);

        // Protocol error: requester withdraws during FWD
        do_reset();
        res_auto = 1'b0;
        req_auto = 1'b0;
        exp_q.push_back(0);
        req = 4'b0001;
        cycle();
        check("perr_res_req", 32'(res_req), 1);
        check("perr_clear_before", 32'(proto_err), 0);
        req = 4'b0000;
        cycle();
        check("perr_set", 32'(proto_err), 1);
        check("perr_fwd_no_ack", 32'(ack), 0);
        cycle();
        check("perr_sticky", 32'(proto_err), 1);
        res_ack = 1'b1;
        cycle();
        check("perr_hold_ack", 32'(ack), 4'b0001);
        cycle();
        check("perr_rtz_res_req", 32'(res_req), 0);
        check("perr_rtz_ack", 32'(ack), 4'b0001);
        res_ack = 1'b0;
        cycle();
        check("perr_idle_ack", 32'(ack), 0);
        check("perr_idle_busy", 32'(busy), 0);
        check("perr_still_set", 32'(proto_err), 1);

        // Reset asserted mid-handshake while in HOLD
        res_seen = 1'b0;
        res_auto = 1'b1;
        exp_q.push_back(2);
        req = 4'b0100;
        n = 0;
        while (ack != 4'b0100 && n < 20) begin
            cycle();
            n++;
        end
        check("midrst_reach_hold", 32'(ack), 4'b0100);
        check("midrst_res_req_before", 32'(res_req), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ack", 32'(ack), 0);
        check("midrst_res_req", 32'(res_req), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_proto_err", 32'(proto_err), 0);
        req      = 4'b0110;
        res_ack  = 1'b0;
        res_seen = 1'b0;
        res_cnt  = 0;
        prev_ack = '0;
        @(negedge clk);
        rst_n    = 1'b1;
        req_auto = 1'b1;
        exp_q.push_back(1);
        exp_q.push_back(2);
        run_done(200);

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
